my_keyboard: RTL
================

MY_KEYBOARD -- requirements
Module: my_keyboard

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 20000, clk cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: ps2_clk  input  1  raw PS/2 clock from the device; asynchronous to clk.
REQ-005 Port: ps2_data  input  1  raw PS/2 data; asynchronous to clk.
REQ-006 Port: scancode  output  16  Hack key code of the held key, 0 when no key is held; drives the keyboard word of the memory map.
REQ-007 Port: frame_err  output  1  one-cycle pulse on a framing, parity or timeout error.

Function
REQ-008 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is synced ps2_clk going 1 to 0 between consecutive clk cycles.
REQ-009 Receiver FSM SHALL have states IDLE, DATA, PARITY, STOP, sampling synced ps2_data only on falling edges.
REQ-010 IDLE: a falling edge with data 0 (start bit) SHALL go to DATA; with data 1, it SHALL stay in IDLE without pulsing frame_err.
REQ-011 DATA SHALL shift in 8 bits LSB first, then go to PARITY; PARITY SHALL capture one bit, then go to STOP.
REQ-012 STOP: a falling edge SHALL complete the frame and return to IDLE; the byte is accepted only if the stop bit is 1 and the 8 data bits plus the parity bit have odd parity.
REQ-013 A rejected frame SHALL pulse frame_err, discard the byte, and clear both prefix flags.
REQ-014 In any state other than IDLE, TIMEOUT_CYCLES clk cycles with no falling edge SHALL force IDLE, pulse frame_err, and clear both prefix flags.
REQ-015 Decoder: accepted byte 0xE0 SHALL set ext_pending; 0xF0 SHALL set brk_pending; neither byte changes scancode.
REQ-016 Any other accepted byte SHALL be looked up as (ext_pending, byte), and both flags SHALL then be cleared.
REQ-017 Lookup SHALL map: A-Z (0x1C,0x32,0x21,0x23,0x24,0x2B,0x34,0x33,0x43,0x3B,0x42,0x4B,0x3A,0x31,0x44,0x4D,0x15,0x2D,0x1B,0x2C,0x3C,0x2A,0x1D,0x22,0x35,0x1A) -> 65..90.
REQ-018 Lookup SHALL map: digits 0-9 (0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46) -> 48..57; space 0x29 -> 32; enter 0x5A -> 128; backspace 0x66 -> 129; esc 0x76 -> 140.
REQ-019 Lookup SHALL map the extended arrows E0+0x6B/0x75/0x74/0x72 -> 130/131/132/133.
REQ-020 Make with a mapped code SHALL load scancode with that code; a new make while another key is held SHALL replace it; typematic repeats leave the value unchanged.
REQ-021 Break whose mapped code equals the current scancode SHALL clear scancode to 0; a break of any other key SHALL leave scancode unchanged.
REQ-022 Unmapped codes (make or break) SHALL be ignored; scancode is unchanged.
REQ-023 scancode SHALL update exactly 1 clk cycle after the cycle in which the stop-bit falling edge is detected; frame_err SHALL assert in that same following cycle.
REQ-024 scancode SHALL be registered and stable between updates; bits 15:8 are always 0.

Reset
REQ-025 On reset assertion, asynchronously: FSM = IDLE; scancode = 0; frame_err = 0; shift register, bit counter, timeout counter, prefix flags and synchronizers = 0.
REQ-026 Reset mid-frame SHALL abandon the partial byte; after release, reception restarts at the next start bit.

Structure
REQ-027 A shared package my_keyboard_pkg SHALL hold the FSM state enum, the Hack key-code constants (128-140 range), and the PS/2 prefix constants 0xE0/0xF0.
REQ-028 The lookup SHALL be a combinational sub-module my_ps2_keymap (inputs: ext flag, 8-bit code; outputs: 8-bit Hack code, valid).

Verification
REQ-029 Frame 0x1C (valid parity/stop) -> scancode = 65 one cycle after the stop edge; frame_err stays 0.
REQ-030 Frames 0x1C, F0, 0x1C -> scancode 65 then 0; frames 0x1C, 0x32, F0, 0x1C -> scancode stays 66.
REQ-031 Frames E0, 0x75 -> scancode 131; then E0, F0, 0x75 -> 0; frame 0x75 alone -> scancode 140 is NOT produced (maps to unmapped, unchanged).
REQ-032 Frame 0x1C with parity bit inverted -> one-cycle frame_err pulse; scancode unchanged; the next valid 0x29 -> 32.
REQ-033 Start bit plus 5 data bits, then idle for TIMEOUT_CYCLES -> frame_err pulse and FSM = IDLE; the next full 0x45 frame -> 48.
REQ-034 Reset asserted after 4 data bits -> scancode 0 immediately; after release, frame 0x5A -> 128.

Source files
------------

// File: rtl/my_keyboard_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and Hack key-code decoder.
package my_keyboard_pkg;

  // Receiver states; the FSM only advances on synchronized PS/2 falling edges.
  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // PS/2 set-2 prefix bytes.
  localparam logic [7:0] PrefixExt = 8'hE0;
  localparam logic [7:0] PrefixBrk = 8'hF0;

  // Hack special key codes.
  localparam logic [7:0] KeyEnter     = 8'd128;
  localparam logic [7:0] KeyBackspace = 8'd129;
  localparam logic [7:0] KeyLeft      = 8'd130;
  localparam logic [7:0] KeyUp        = 8'd131;
  localparam logic [7:0] KeyRight     = 8'd132;
  localparam logic [7:0] KeyDown      = 8'd133;
  localparam logic [7:0] KeyEsc       = 8'd140;

  // Printable Hack codes used by the keymap.
  localparam logic [7:0] KeySpace = 8'd32;

endpackage

// File: rtl/my_ps2_keymap.sv
// Combinational PS/2 set-2 scan code to Hack key code lookup.
module my_ps2_keymap
  import my_keyboard_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_code,
  output logic [7:0] o_hack,
  output logic       o_valid
);

  // Extended codes only cover the arrow keys; everything else is unmapped.
  always_comb begin
    o_hack  = 8'd0;
    o_valid = 1'b1;
    if (i_ext) begin
      case (i_code)
        8'h6B:   o_hack = KeyLeft;
        8'h75:   o_hack = KeyUp;
        8'h74:   o_hack = KeyRight;
        8'h72:   o_hack = KeyDown;
        default: o_valid = 1'b0;
      endcase
    end else begin
      case (i_code)
        8'h1C:   o_hack = 8'd65;  // A
        8'h32:   o_hack = 8'd66;
        8'h21:   o_hack = 8'd67;
        8'h23:   o_hack = 8'd68;
        8'h24:   o_hack = 8'd69;
        8'h2B:   o_hack = 8'd70;
        8'h34:   o_hack = 8'd71;
        8'h33:   o_hack = 8'd72;
        8'h43:   o_hack = 8'd73;
        8'h3B:   o_hack = 8'd74;
        8'h42:   o_hack = 8'd75;
        8'h4B:   o_hack = 8'd76;
        8'h3A:   o_hack = 8'd77;
        8'h31:   o_hack = 8'd78;
        8'h44:   o_hack = 8'd79;
        8'h4D:   o_hack = 8'd80;
        8'h15:   o_hack = 8'd81;
        8'h2D:   o_hack = 8'd82;
        8'h1B:   o_hack = 8'd83;
        8'h2C:   o_hack = 8'd84;
        8'h3C:   o_hack = 8'd85;
        8'h2A:   o_hack = 8'd86;
        8'h1D:   o_hack = 8'd87;
        8'h22:   o_hack = 8'd88;
        8'h35:   o_hack = 8'd89;
        8'h1A:   o_hack = 8'd90;  // Z
        8'h45:   o_hack = 8'd48;  // 0
        8'h16:   o_hack = 8'd49;
        8'h1E:   o_hack = 8'd50;
        8'h26:   o_hack = 8'd51;
        8'h25:   o_hack = 8'd52;
        8'h2E:   o_hack = 8'd53;
        8'h36:   o_hack = 8'd54;
        8'h3D:   o_hack = 8'd55;
        8'h3E:   o_hack = 8'd56;
        8'h46:   o_hack = 8'd57;  // 9
        8'h29:   o_hack = KeySpace;
        8'h5A:   o_hack = KeyEnter;
        8'h66:   o_hack = KeyBackspace;
        8'h76:   o_hack = KeyEsc;
        default: o_valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/my_keyboard.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, deframes 11-bit frames,
// tracks E0/F0 prefixes and holds the Hack code of the currently pressed key.
module my_keyboard
  import my_keyboard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] scancode,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_clk_prev;
  rx_state_e     r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_parity;
  logic [TW-1:0] r_timer;
  logic          r_ext;
  logic          r_brk;
  logic [7:0]    r_scancode;
  logic          r_frame_err;

  logic          w_fall;
  logic          w_bit;
  logic          w_frame_ok;
  logic [7:0]    w_hack;
  logic          w_hack_valid;

  assign w_fall = r_clk_prev & ~r_clk_sync[1];
  assign w_bit  = r_data_sync[1];
  // Accept only a high stop bit with odd parity across data plus parity bit.
  assign w_frame_ok = w_bit & (^{r_shift, r_parity});

  assign scancode  = {8'h00, r_scancode};
  assign frame_err = r_frame_err;

  my_ps2_keymap u_keymap (
    .i_ext   (r_ext),
    .i_code  (r_shift),
    .o_hack  (w_hack),
    .o_valid (w_hack_valid)
  );

  // Two-flop synchronizers for both PS/2 lines plus the edge-detect history flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= 2'b00;
      r_data_sync <= 2'b00;
      r_clk_prev  <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  // Receiver FSM, inter-edge timeout and prefix-aware scancode decoder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_parity    <= 1'b0;
      r_timer     <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_scancode  <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;

      if (w_fall) begin
        r_timer <= '0;
        unique case (r_state)
          StIdle: begin
            // A high start bit is line noise; stay idle silently.
            if (!w_bit) begin
              r_state   <= StData;
              r_bit_cnt <= 3'd0;
            end
          end
          StData: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= StParity;
            end
          end
          StParity: begin
            r_parity <= w_bit;
            r_state  <= StStop;
          end
          StStop: begin
            r_state <= StIdle;
            if (!w_frame_ok) begin
              r_frame_err <= 1'b1;
              r_ext       <= 1'b0;
              r_brk       <= 1'b0;
            end else if (r_shift == PrefixExt) begin
              r_ext <= 1'b1;
            end else if (r_shift == PrefixBrk) begin
              r_brk <= 1'b1;
            end else begin
              if (w_hack_valid) begin
                if (!r_brk) begin
                  r_scancode <= w_hack;
                end else if (w_hack == r_scancode) begin
                  r_scancode <= 8'h00;
                end
              end
              r_ext <= 1'b0;
              r_brk <= 1'b0;
            end
          end
        endcase
      end else if (r_state != StIdle) begin
        // A stalled device must not wedge the receiver mid-frame.
        if (r_timer == TimeoutLast) begin
          r_state     <= StIdle;
          r_timer     <= '0;
          r_frame_err <= 1'b1;
          r_ext       <= 1'b0;
          r_brk       <= 1'b0;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end
    end
  end

endmodule
